// File: rtl/decimal_keypad_encoder.sv
// Debounced, priority-encoding keypad front end: one binary code per key press,
// presented on a valid/ready slot with multi-key and dropped-press flags.
module decimal_keypad_encoder #(
    parameter int N_KEYS       = 10,
    parameter int CODE_W       = $clog2(N_KEYS),
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys,
    input  logic              ready,
    output logic [CODE_W-1:0] code_out,
    output logic              valid,
    output logic              multi_err,
    output logic              overflow,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // Handshake: a code transfers on any rising edge where valid && ready;
    // valid never drops without a transfer, and code_out is held while valid && !ready.

    localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_KEYS-1:0]   keys_q;
    logic [N_KEYS-1:0]   cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                valid_q, valid_d;
    logic                multi_q, multi_d;
    logic                ovf_q, ovf_d;
    logic                emit;

    function automatic logic [CODE_W-1:0] top_index(input logic [N_KEYS-1:0] v);
        top_index = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) top_index = CODE_W'(i);
        end
    endfunction

    function automatic logic more_than_one(input logic [N_KEYS-1:0] v);
        more_than_one = (v & (v - N_KEYS'(1))) != '0;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            keys_q  <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (keys_q != '0) begin
                    cand_d  = keys_q;
                    cnt_d   = CNT_ONE;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (keys_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        emit    = 1'b1;
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (keys_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cand_d = keys_q;
                    cnt_d  = CNT_ONE;
                end
            end
            PRESSED: begin
                // Pattern changes while held are ignored; only a release matters.
                if (keys_q == '0) begin
                    cnt_d   = CNT_ONE;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (keys_q != '0) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q & ~ready;
        multi_d = 1'b0;
        ovf_d   = ovf_q;
        if (emit) begin
            multi_d = more_than_one(cand_q);
            // A same-edge accept frees the slot for the new code.
            if (!valid_q || ready) begin
                code_d  = top_index(cand_q);
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign code_out  = code_q;
    assign valid     = valid_q;
    assign multi_err = multi_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_decimal_keypad_encoder.sv
// Bench for decimal_keypad_encoder: directed scenarios plus random key traffic,
// checked every cycle against a run-length model of the debounced key stream.
module tb_decimal_keypad_encoder;

    localparam int N   = 10;
    localparam int CW  = 4;
    localparam int DEB = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  keys;
    logic          ready;
    logic [CW-1:0] code_out;
    logic          valid;
    logic          multi_err;
    logic          overflow;
    logic          busy;
    logic [1:0]    state_dbg;

    decimal_keypad_encoder #(.N_KEYS(N), .CODE_W(CW), .DEBOUNCE_CYC(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys      (keys),
        .ready     (ready),
        .code_out  (code_out),
        .valid     (valid),
        .multi_err (multi_err),
        .overflow  (overflow),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: the key stream as the debouncer sees it (one cycle late),
    // tracked as runs of identical samples
    logic [N-1:0]  m_kq;
    logic [N-1:0]  m_pat;
    int            m_run;
    bit            m_held;
    logic          m_valid, m_multi, m_ovf, m_busy;
    logic [CW-1:0] m_code;
    logic [CW-1:0] exp_q[$];
    logic [CW-1:0] last_code;

    function automatic logic [CW-1:0] highest_key(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i] && r < 0) r = i;
        end
        return CW'(r);
    endfunction

    task automatic model_edge();
        logic [N-1:0]  seen;
        logic [CW-1:0] front;
        bit            emit;
        bit            accepted;
        if (reset) begin
            m_kq = '0; m_pat = '0; m_run = 0; m_held = 0;
            m_valid = 0; m_code = '0; m_multi = 0; m_ovf = 0; m_busy = 0;
            exp_q.delete();
        end else begin
            seen = m_kq;
            m_kq = keys;
            if (seen == m_pat) m_run++;
            else begin
                m_pat = seen;
                m_run = 1;
            end
            emit = 0;
            if (!m_held && seen != 0 && m_run == DEB) begin
                emit   = 1;
                m_held = 1;
            end else if (m_held && seen == 0 && m_run == DEB) begin
                m_held = 0;
            end
            accepted = m_valid && ready;
            if (accepted) begin
                check("scoreboard_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    front = exp_q.pop_front();
                    check("accepted_code", last_code, front);
                end
            end
            m_multi = emit && ($countones(seen) > 1);
            if (emit && (!m_valid || ready)) begin
                m_code  = highest_key(seen);
                m_valid = 1;
                exp_q.push_back(m_code);
            end else begin
                if (emit) m_ovf = 1;
                if (accepted) m_valid = 0;
            end
            m_busy = m_held || (seen != 0);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("valid", valid, m_valid);
        check("code_out", code_out, m_code);
        check("multi_err", multi_err, m_multi);
        check("overflow", overflow, m_ovf);
        check("busy", busy, m_busy);
        last_code = code_out;
    endtask

    task automatic hold(input logic [N-1:0] k, input int n, input logic r);
        keys  = k;
        ready = r;
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] k;
        last_code = '0;
        keys  = '0;
        ready = 1'b1;
        do_reset(2);

        // single key 7
        hold(10'h080, 12, 1'b1);
        hold('0, 8, 1'b1);
        // keys 3 and 9 together
        hold(10'h208, 10, 1'b1);
        hold('0, 8, 1'b1);
        // short bounce, never debounced
        hold(10'h010, 2, 1'b1);
        hold('0, 6, 1'b1);
        check("bounce_not_busy", busy, 0);
        // consumer stalled: second press dropped
        hold(10'h020, 8, 1'b0);
        hold('0, 10, 1'b0);
        hold(10'h004, 8, 1'b0);
        hold('0, 8, 1'b0);
        check("stall_code", code_out, 5);
        check("stall_overflow", overflow, 1);
        hold('0, 3, 1'b1);
        // release glitch while held
        hold(10'h002, 8, 1'b1);
        hold('0, 1, 1'b1);
        hold(10'h002, 6, 1'b1);
        hold('0, 8, 1'b1);
        // reset in the middle of debouncing key 4
        hold(10'h010, 3, 1'b1);
        do_reset(1);
        check("reset_valid", valid, 0);
        check("reset_overflow", overflow, 0);
        hold(10'h010, 8, 1'b1);
        hold('0, 8, 1'b1);
        // key 0 encodes to zero
        hold(10'h001, 8, 1'b0);
        check("key0_valid", valid, 1);
        check("key0_code", code_out, 0);
        hold('0, 8, 1'b1);

        // random traffic
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 9))
                0, 1:    k = '0;
                2:       k = N'($urandom_range(1, (1 << N) - 1));
                default: k = N'(1) << $urandom_range(0, N - 1);
            endcase
            hold(k, $urandom_range(1, 8), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
        end
        hold('0, 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
